// File: rtl/arm_dp_pkg.sv
// Shared types and constants for the ARM data-processing operand stage.
//   alu_ctrl_t : ALU operation codes (equal to the instruction cmd field)
//   shift_t    : Operand2 register shift types
//   COND_AL    : "always" condition code, the only one supported
//   REG_PC     : R15, not supported as an operand or destination
//   NREGS      : number of architectural registers (R0..R14)
package arm_dp_pkg;

    localparam int unsigned NREGS   = 15;
    localparam logic [3:0]  COND_AL = 4'b1110;
    localparam logic [3:0]  REG_PC  = 4'd15;

    typedef enum logic [3:0] {
        AluAnd = 4'b0000,
        AluSub = 4'b0010,
        AluAdd = 4'b0100,
        AluOrr = 4'b1100
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        ShLsl = 2'b00,
        ShLsr = 2'b01,
        ShAsr = 2'b10,
        ShRor = 2'b11
    } shift_t;

    function automatic logic cmd_supported(input logic [3:0] cmd);
        return (cmd == AluAnd) || (cmd == AluSub) || (cmd == AluAdd) || (cmd == AluOrr);
    endfunction

endpackage

// File: rtl/arm_regfile.sv
// Register file R0..R14, 32 bits each.
//   clk, rst_n     : clock, asynchronous active-low reset (clears all entries)
//   raddr1/rdata1  : combinational read port 1
//   raddr2/rdata2  : combinational read port 2
//   we/waddr/wdata : write port; writes to R15 are ignored
// Reads of the register being written this cycle return wdata (write-through).
module arm_regfile
    import arm_dp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [3:0]  raddr2,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] mem_q [NREGS];
    logic        wr_ok;

    assign wr_ok = we && (waddr != REG_PC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (wr_ok && (raddr1 == waddr)) begin
            rdata1 = wdata;
        end else if (raddr1 != REG_PC) begin
            rdata1 = mem_q[raddr1];
        end
        if (wr_ok && (raddr2 == waddr)) begin
            rdata2 = wdata;
        end else if (raddr2 != REG_PC) begin
            rdata2 = mem_q[raddr2];
        end
    end

endmodule

// File: rtl/arm_dp_operand_stage.sv
// Decode / operand-fetch stage in front of the data-processing ALU.
//   clk, rst_n              : clock, asynchronous active-low reset
//   Instr, InstrValid       : incoming instruction word and its valid
//   InstrReady              : stage accepts Instr this cycle
//   A, B, ALUControl, Rd    : registered operands, ALU op code, destination
//   OutValid, OutReady      : output handshake toward the ALU stage
//   WbEn, WbAddr, WbData    : writeback port (regfile write, scoreboard clear)
//   Illegal                 : one-cycle pulse after an illegal word was consumed
module arm_dp_operand_stage
    import arm_dp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Instr,
    input  logic        InstrValid,
    output logic        InstrReady,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [3:0]  ALUControl,
    output logic [3:0]  Rd,
    output logic        OutValid,
    input  logic        OutReady,
    input  logic        WbEn,
    input  logic [3:0]  WbAddr,
    input  logic [31:0] WbData,
    output logic        Illegal
);

    // Decode fields
    logic [3:0]  cond, cmd, rn, rd, rm, rot;
    logic [1:0]  op;
    logic        ibit;
    logic [4:0]  shamt;
    shift_t      sh_type;
    logic        unused_sbit;

    assign cond        = Instr[31:28];
    assign op          = Instr[27:26];
    assign ibit        = Instr[25];
    assign cmd         = Instr[24:21];
    assign rn          = Instr[19:16];
    assign rd          = Instr[15:12];
    assign rot         = Instr[11:8];
    assign shamt       = Instr[11:7];
    assign sh_type     = shift_t'(Instr[6:5]);
    assign rm          = Instr[3:0];
    assign unused_sbit = Instr[20];

    logic legal;
    assign legal = (op == 2'b00) && (cond == COND_AL) && cmd_supported(cmd) &&
                   (rn != REG_PC) && (rd != REG_PC) &&
                   (ibit || ((rm != REG_PC) && !Instr[4]));

    // Register file
    logic [31:0] rn_val, rm_val;

    arm_regfile u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr1 (rn),
        .rdata1 (rn_val),
        .raddr2 (rm),
        .rdata2 (rm_val),
        .we     (WbEn),
        .waddr  (WbAddr),
        .wdata  (WbData)
    );

    // Scoreboard and hazard detection
    logic [NREGS-1:0] pending_q, pending_d, clr_mask, set_mask, pend_eff;
    logic [15:0]      pend_ext;
    logic             hazard, accept, out_valid_q;

    always_comb begin
        clr_mask = '0;
        if (WbEn && (WbAddr != REG_PC)) begin
            clr_mask[WbAddr] = 1'b1;
        end
    end

    // A same-cycle writeback counts as not pending: the bypass supplies the data.
    assign pend_eff = pending_q & ~clr_mask;
    assign pend_ext = {1'b0, pend_eff};
    assign hazard   = legal && (pend_ext[rn] || (!ibit && pend_ext[rm]));

    assign InstrReady = (!out_valid_q || OutReady) && !hazard;
    assign accept     = InstrValid && InstrReady;

    always_comb begin
        set_mask = '0;
        if (accept && legal) begin
            set_mask[rd] = 1'b1;
        end
    end

    // Set after clear so that a same-register collision leaves the bit set.
    assign pending_d = pend_eff | set_mask;

    // Operand2
    logic [31:0] imm32, imm_rot, shifted, op2;
    logic [4:0]  rot_amt;

    assign imm32   = {24'b0, Instr[7:0]};
    assign rot_amt = {rot, 1'b0};
    // Shifts by 32 yield zero, so rotate-by-zero falls out naturally.
    assign imm_rot = (imm32 >> rot_amt) | (imm32 << (6'd32 - {1'b0, rot_amt}));

    always_comb begin
        shifted = rm_val;
        unique case (sh_type)
            ShLsl: shifted = rm_val << shamt;
            ShLsr: shifted = rm_val >> shamt;
            ShAsr: shifted = $signed(rm_val) >>> shamt;
            ShRor: shifted = (rm_val >> shamt) | (rm_val << (6'd32 - {1'b0, shamt}));
            default: shifted = rm_val;
        endcase
    end

    assign op2 = ibit ? imm_rot : shifted;

    // State
    logic [31:0] a_q, b_q;
    logic [3:0]  alu_q, rd_q;
    logic        illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            alu_q       <= '0;
            rd_q        <= '0;
        end else begin
            pending_q <= pending_d;
            illegal_q <= accept && !legal;
            if (accept && legal) begin
                out_valid_q <= 1'b1;
                a_q         <= rn_val;
                b_q         <= op2;
                alu_q       <= cmd;
                rd_q        <= rd;
            end else if (OutReady) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign A          = a_q;
    assign B          = b_q;
    assign ALUControl = alu_q;
    assign Rd         = rd_q;
    assign OutValid   = out_valid_q;
    assign Illegal    = illegal_q;

endmodule

// File: tb/tb_arm_dp_operand_stage.sv
module tb_arm_dp_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] Instr = '0;
    logic        InstrValid = 1'b0;
    logic        InstrReady;
    logic [31:0] A, B;
    logic [3:0]  ALUControl, Rd;
    logic        OutValid;
    logic        OutReady = 1'b1;
    logic        WbEn = 1'b0;
    logic [3:0]  WbAddr = '0;
    logic [31:0] WbData = '0;
    logic        Illegal;

    int checks = 0;
    int errors = 0;

    arm_dp_operand_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Instr      (Instr),
        .InstrValid (InstrValid),
        .InstrReady (InstrReady),
        .A          (A),
        .B          (B),
        .ALUControl (ALUControl),
        .Rd         (Rd),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .WbEn       (WbEn),
        .WbAddr     (WbAddr),
        .WbData     (WbData),
        .Illegal    (Illegal)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [15];
    bit          m_pend [15];
    bit          m_ov, m_ill;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_alu, m_rd;

    function automatic bit m_legal(input logic [31:0] w);
        int c;
        c = int'(w[24:21]);
        if (w[31:28] != 4'd14 || w[27:26] != 2'd0) return 0;
        if (!(c == 4 || c == 2 || c == 0 || c == 12)) return 0;
        if (w[19:16] == 4'd15 || w[15:12] == 4'd15) return 0;
        if (!w[25] && (w[3:0] == 4'd15 || w[4])) return 0;
        return 1;
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] r);
        if (WbEn && WbAddr == r && r != 4'd15) return WbData;
        return m_regs[r];
    endfunction

    function automatic bit m_busy(input logic [3:0] r);
        if (WbEn && WbAddr == r) return 0;
        return m_pend[r];
    endfunction

    function automatic logic [31:0] m_op2(input logic [31:0] w);
        logic [31:0] v;
        if (w[25]) begin
            v = {24'b0, w[7:0]};
            for (int k = 0; k < 2 * int'(w[11:8]); k++) v = {v[0], v[31:1]};
        end else begin
            v = m_read(w[3:0]);
            for (int k = 0; k < int'(w[11:7]); k++) begin
                case (w[6:5])
                    2'd0: v = {v[30:0], 1'b0};
                    2'd1: v = {1'b0, v[31:1]};
                    2'd2: v = {v[31], v[31:1]};
                    default: v = {v[0], v[31:1]};
                endcase
            end
        end
        return v;
    endfunction

    function automatic bit exp_ready();
        bit hz;
        hz = 0;
        if (m_legal(Instr)) begin
            if (m_busy(Instr[19:16])) hz = 1;
            if (!Instr[25] && m_busy(Instr[3:0])) hz = 1;
        end
        return (!m_ov || OutReady) && !hz;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) begin
                m_regs[i] = '0;
                m_pend[i] = 0;
            end
            m_ov = 0; m_ill = 0; m_a = '0; m_b = '0; m_alu = '0; m_rd = '0;
        end else begin
            bit acc, lg;
            acc = InstrValid && exp_ready();
            lg  = m_legal(Instr);
            if (acc && lg) begin
                m_a   = m_read(Instr[19:16]);
                m_b   = m_op2(Instr);
                m_alu = Instr[24:21];
                m_rd  = Instr[15:12];
                m_ov  = 1;
            end else if (OutReady) begin
                m_ov = 0;
            end
            m_ill = acc && !lg;
            if (WbEn && WbAddr != 4'd15) m_pend[WbAddr] = 0;
            if (acc && lg) m_pend[Instr[15:12]] = 1;
            if (WbEn && WbAddr != 4'd15) m_regs[WbAddr] = WbData;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("InstrReady", 32'(InstrReady), 32'(exp_ready()));
        chk("OutValid", 32'(OutValid), 32'(m_ov));
        chk("Illegal", 32'(Illegal), 32'(m_ill));
        if (m_ov || !rst_n) begin
            chk("A", A, m_a);
            chk("B", B, m_b);
            chk("ALUControl", 32'(ALUControl), 32'(m_alu));
            chk("Rd", 32'(Rd), 32'(m_rd));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [3:0] a, input logic [31:0] d);
        WbEn = 1; WbAddr = a; WbData = d;
        tick();
        WbEn = 0;
    endtask

    task automatic issue_one(input logic [31:0] w);
        Instr = w; InstrValid = 1;
        tick();
        InstrValid = 0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int r;
        int cmds [4];
        cmds = '{0, 2, 4, 12};
        r = $urandom_range(0, 11);
        if (r == 0) return $urandom;
        w = $urandom;
        w[31:28] = (r == 1) ? 4'($urandom) : 4'hE;
        w[27:26] = 2'b00;
        w[24:21] = (r == 2) ? 4'($urandom) : 4'(cmds[$urandom_range(0, 3)]);
        w[19:16] = (r == 3) ? 4'd15 : 4'($urandom_range(0, 14));
        w[15:12] = 4'($urandom_range(0, 14));
        if (!w[25]) begin
            w[3:0] = 4'($urandom_range(0, 14));
            if (r != 4) w[4] = 1'b0;
        end
        return w;
    endfunction

    initial begin
        logic [31:0] hold_a, hold_b;

        // Reset held low
        repeat (3) tick();
        @(negedge clk);
        chk("rst_OutValid", 32'(OutValid), 32'd0);
        chk("rst_InstrReady", 32'(InstrReady), 32'd1);
        chk("rst_A", A, 32'd0);
        chk("rst_B", B, 32'd0);
        chk("rst_ALU_Rd", {24'd0, ALUControl, Rd}, 32'd0);
        tick();
        rst_n = 1;

        wb(4'd1, 32'd5);
        wb(4'd2, 32'd3);

        issue_one(32'hE0810002);
        @(negedge clk);
        chk("add_A", A, 32'd5);
        chk("add_B", B, 32'd3);
        chk("add_ALU", 32'(ALUControl), 32'h4);
        chk("add_Rd", 32'(Rd), 32'd0);

        issue_one(32'hE38134FF);
        @(negedge clk);
        chk("orr_B", B, 32'hFF000000);
        chk("orr_ALU", 32'(ALUControl), 32'hC);

        wb(4'd2, 32'h80000000);
        issue_one(32'hE0414242);
        @(negedge clk);
        chk("sub_B", B, 32'hF8000000);
        chk("sub_ALU", 32'(ALUControl), 32'h2);

        // Dependency stall on R0
        wb(4'd0, 32'd0);
        issue_one(32'hE0810002);
        Instr = 32'hE0805001; InstrValid = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("dep_stall_ready", 32'(InstrReady), 32'd0);
            tick();
        end
        WbEn = 1; WbAddr = 4'd0; WbData = 32'd8;
        @(negedge clk);
        chk("dep_wb_ready", 32'(InstrReady), 32'd1);
        tick();
        WbEn = 0; InstrValid = 0;
        @(negedge clk);
        chk("dep_A", A, 32'd8);
        chk("dep_Rd", 32'(Rd), 32'd5);

        // Illegal words: cond=0, MUL-class, Rn=15
        foreach (hold_a[i]) begin end
        for (int k = 0; k < 3; k++) begin
            logic [31:0] words [3];
            words = '{32'h00810002, 32'hE0000291, 32'hE08F0002};
            issue_one(words[k]);
            @(negedge clk);
            chk("ill_pulse", 32'(Illegal), 32'd1);
            chk("ill_noout", 32'(OutValid), 32'd0);
            tick();
            @(negedge clk);
            chk("ill_end", 32'(Illegal), 32'd0);
        end

        // Output hold under back-pressure
        OutReady = 0;
        issue_one(32'hE0816002);
        @(negedge clk);
        hold_a = A; hold_b = B;
        chk("hold_B_val", hold_b, 32'h80000000);
        Instr = 32'hE0817002; InstrValid = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_ready", 32'(InstrReady), 32'd0);
            chk("hold_valid", 32'(OutValid), 32'd1);
            chk("hold_A", A, hold_a);
            chk("hold_B", B, hold_b);
            chk("hold_Rd", 32'(Rd), 32'd6);
            tick();
        end
        OutReady = 1;
        tick();
        InstrValid = 0;

        // Randomised phase
        for (int c = 0; c < 3000; c++) begin
            Instr      = rand_instr();
            InstrValid = ($urandom_range(0, 3) != 0);
            OutReady   = ($urandom_range(0, 3) != 0);
            WbEn       = ($urandom_range(0, 4) < 2);
            WbAddr     = 4'($urandom);
            WbData     = $urandom;
            if (c == 1500) begin
                #2 rst_n = 0;
                tick();
                rst_n = 1;
            end else begin
                tick();
            end
        end
        InstrValid = 0;
        WbEn = 0;
        tick();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
